// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared types and widths for the fetch-to-dispatch instruction buffer
`ifndef N
`define N 3
`endif

package inst_buffer_pkg;

  typedef logic [31:0] INST;
  typedef logic [31:0] ADDR;

  typedef struct packed {
    INST inst;
    ADDR PC;
    ADDR NPC;
  } FETCH_PACKET;

  localparam int SUPERSCALAR_WIDTH = `N;
  localparam int NUM_SCALAR_BITS   = $clog2(`N + 1);
  localparam int INST_BUFFER_DEPTH = 16;

endpackage

// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - fetch and dispatch side signals of the instruction buffer
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int N = `N
) ();

  FETCH_PACKET [N-1:0]        inst_buffer_inputs;
  logic [NUM_SCALAR_BITS-1:0] instructions_valid;
  logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots;
  FETCH_PACKET [N-1:0]        dispatch_outputs;
  logic [NUM_SCALAR_BITS-1:0] outputs_valid;
  logic [NUM_SCALAR_BITS-1:0] num_dispatched;

  // Fetch/Dispatch side
  modport master (
    output inst_buffer_inputs,
    output instructions_valid,
    output num_dispatched,
    input  inst_buffer_spots,
    input  dispatch_outputs,
    input  outputs_valid
  );

  // Buffer side
  modport slave (
    input  inst_buffer_inputs,
    input  instructions_valid,
    input  num_dispatched,
    output inst_buffer_spots,
    output dispatch_outputs,
    output outputs_valid
  );

endinterface

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - N-wide circular FIFO between fetch and dispatch with flush
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int N     = `N,
  parameter int DEPTH = INST_BUFFER_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  inst_buffer_if.slave ib
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  FETCH_PACKET                entries [DEPTH];
  logic [IDX_W-1:0]           head;
  logic [IDX_W-1:0]           tail;
  logic [CNT_W-1:0]           count;

  logic [CNT_W-1:0]           free_cnt;
  logic [NUM_SCALAR_BITS-1:0] spots;
  logic [NUM_SCALAR_BITS-1:0] avail;
  logic [NUM_SCALAR_BITS-1:0] pushed;
  logic [NUM_SCALAR_BITS-1:0] popped;
  FETCH_PACKET [N-1:0]        out_pkts;

  // Space and occupancy depend only on the registered count, so a pop never frees room for a same-cycle push
  always_comb begin
    free_cnt = CNT_W'(DEPTH) - count;
    spots    = (free_cnt < CNT_W'(N)) ? NUM_SCALAR_BITS'(free_cnt) : NUM_SCALAR_BITS'(N);
    avail    = (count < CNT_W'(N)) ? NUM_SCALAR_BITS'(count) : NUM_SCALAR_BITS'(N);
    pushed   = (ib.instructions_valid < spots) ? ib.instructions_valid : spots;
    popped   = (ib.num_dispatched < avail) ? ib.num_dispatched : avail;
  end

  // Present the oldest N entries starting at head; pointer arithmetic wraps at DEPTH
  always_comb begin
    out_pkts = '0;
    for (int i = 0; i < N; i++) begin
      out_pkts[i] = entries[head + IDX_W'(i)];
    end
  end

  assign ib.inst_buffer_spots = spots;
  assign ib.outputs_valid     = avail;
  assign ib.dispatch_outputs  = out_pkts;

  // Storage and pointer update: reset clears everything, flush only drops the pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        entries[d] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i < int'(pushed)) begin
          entries[tail + IDX_W'(i)] <= ib.inst_buffer_inputs[i];
        end
      end
      head  <= head + IDX_W'(popped);
      tail  <= tail + IDX_W'(pushed);
      count <= count + CNT_W'(pushed) - CNT_W'(popped);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed self-checking bench for inst_buffer
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clock;
  logic reset;
  logic flush;
  int   passed;
  int   total;

  inst_buffer_if #(.N(3)) ib_if ();

  inst_buffer #(.N(3), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .ib    (ib_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_push(input int n, input logic [31:0] base_pc);
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        ib_if.inst_buffer_inputs[i].PC   = base_pc + 32'(4 * i);
        ib_if.inst_buffer_inputs[i].NPC  = base_pc + 32'(4 * i) + 32'h4;
        ib_if.inst_buffer_inputs[i].inst = 32'hA000_0000 ^ (base_pc + 32'(4 * i));
      end else begin
        ib_if.inst_buffer_inputs[i] = '0;
      end
    end
    ib_if.instructions_valid = 2'(n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL reset_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL reset_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs !== '0) $display("FAIL reset_outputs: got %0h expected 0", ib_if.dispatch_outputs); else passed++;
    step();
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL idle_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
  endtask

  task automatic test_push_basic();
    drive_push(3, 32'h0);
    ib_if.num_dispatched = 2'd0;
    step();
    drive_push(0, 32'h0);
    total++; if (ib_if.outputs_valid !== 2'd3) $display("FAIL basic_ov: got %0d expected 3", ib_if.outputs_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (ib_if.dispatch_outputs[i].PC !== 32'(4 * i)) $display("FAIL basic_pc%0d: got %0h expected %0h", i, ib_if.dispatch_outputs[i].PC, 4 * i); else passed++;
    end
    total++; if (ib_if.dispatch_outputs[1].inst !== 32'hA000_0004) $display("FAIL basic_inst1: got %0h expected a0000004", ib_if.dispatch_outputs[1].inst); else passed++;
    total++; if (ib_if.dispatch_outputs[2].NPC !== 32'hC) $display("FAIL basic_npc2: got %0h expected c", ib_if.dispatch_outputs[2].NPC); else passed++;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL basic_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
  endtask

  task automatic test_fill();
    drive_push(3, 32'hC);
    step();
    total++; if (ib_if.inst_buffer_spots !== 2'd2) $display("FAIL fill6_spots: got %0d expected 2", ib_if.inst_buffer_spots); else passed++;
    drive_push(3, 32'h18);
    step();
    total++; if (ib_if.inst_buffer_spots !== 2'd0) $display("FAIL full_spots: got %0d expected 0", ib_if.inst_buffer_spots); else passed++;
    drive_push(3, 32'h200);
    step();
    drive_push(0, 32'h0);
    total++; if (ib_if.inst_buffer_spots !== 2'd0) $display("FAIL overpush_spots: got %0d expected 0", ib_if.inst_buffer_spots); else passed++;
    total++; if (ib_if.outputs_valid !== 2'd3) $display("FAIL overpush_ov: got %0d expected 3", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'h0) $display("FAIL overpush_pc0: got %0h expected 0", ib_if.dispatch_outputs[0].PC); else passed++;
    ib_if.num_dispatched = 2'd3;
    step();
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'hC) $display("FAIL drain1_pc0: got %0h expected c", ib_if.dispatch_outputs[0].PC); else passed++;
    total++; if (ib_if.dispatch_outputs[2].PC !== 32'h14) $display("FAIL drain1_pc2: got %0h expected 14", ib_if.dispatch_outputs[2].PC); else passed++;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL drain1_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    step();
    total++; if (ib_if.outputs_valid !== 2'd2) $display("FAIL drain2_ov: got %0d expected 2", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'h18) $display("FAIL drain2_pc0: got %0h expected 18", ib_if.dispatch_outputs[0].PC); else passed++;
    total++; if (ib_if.dispatch_outputs[1].PC !== 32'h1C) $display("FAIL drain2_pc1: got %0h expected 1c", ib_if.dispatch_outputs[1].PC); else passed++;
    step();
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL drain3_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
    step();
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL empty_pop_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL empty_pop_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    ib_if.num_dispatched = 2'd0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int          remaining;
    int          exp_ov;
    drive_push(3, 32'h300);
    step();
    drive_push(3, 32'h30C);
    step();
    drive_push(0, 32'h0);
    ib_if.num_dispatched = 2'd3;
    step();
    ib_if.num_dispatched = 2'd2;
    step();
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.outputs_valid !== 2'd1) $display("FAIL wrap_pre_ov: got %0d expected 1", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'h314) $display("FAIL wrap_pre_pc0: got %0h expected 314", ib_if.dispatch_outputs[0].PC); else passed++;
    drive_push(3, 32'h318);
    step();
    drive_push(3, 32'h324);
    step();
    drive_push(0, 32'h0);
    total++; if (ib_if.inst_buffer_spots !== 2'd1) $display("FAIL wrap_spots: got %0d expected 1", ib_if.inst_buffer_spots); else passed++;
    exp_pc    = 32'h314;
    remaining = 7;
    ib_if.num_dispatched = 2'd3;
    for (int it = 0; it < 3; it++) begin
      exp_ov = (remaining < 3) ? remaining : 3;
      total++; if (ib_if.outputs_valid !== 2'(exp_ov)) $display("FAIL wrap_ov%0d: got %0d expected %0d", it, ib_if.outputs_valid, exp_ov); else passed++;
      for (int i = 0; i < exp_ov; i++) begin
        total++; if (ib_if.dispatch_outputs[i].PC !== exp_pc + 32'(4 * i)) $display("FAIL wrap_pc%0d_%0d: got %0h expected %0h", it, i, ib_if.dispatch_outputs[i].PC, exp_pc + 32'(4 * i)); else passed++;
      end
      step();
      exp_pc    = exp_pc + 32'(4 * exp_ov);
      remaining = remaining - exp_ov;
    end
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL wrap_end_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
  endtask

  task automatic test_simultaneous();
    drive_push(3, 32'h400);
    step();
    drive_push(1, 32'h40C);
    step();
    drive_push(3, 32'h410);
    ib_if.num_dispatched = 2'd2;
    step();
    drive_push(0, 32'h0);
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL simul_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'h408) $display("FAIL simul_pc0: got %0h expected 408", ib_if.dispatch_outputs[0].PC); else passed++;
    total++; if (ib_if.dispatch_outputs[1].PC !== 32'h40C) $display("FAIL simul_pc1: got %0h expected 40c", ib_if.dispatch_outputs[1].PC); else passed++;
    total++; if (ib_if.dispatch_outputs[2].PC !== 32'h410) $display("FAIL simul_pc2: got %0h expected 410", ib_if.dispatch_outputs[2].PC); else passed++;
    ib_if.num_dispatched = 2'd3;
    step();
    total++; if (ib_if.outputs_valid !== 2'd2) $display("FAIL simul_tail_ov: got %0d expected 2", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs[1].PC !== 32'h418) $display("FAIL simul_tail_pc1: got %0h expected 418", ib_if.dispatch_outputs[1].PC); else passed++;
    ib_if.num_dispatched = 2'd2;
    step();
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL simul_end_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
  endtask

  task automatic test_flush();
    drive_push(3, 32'h500);
    step();
    drive_push(3, 32'h50C);
    step();
    total++; if (ib_if.inst_buffer_spots !== 2'd2) $display("FAIL preflush_spots: got %0d expected 2", ib_if.inst_buffer_spots); else passed++;
    flush = 1'b1;
    drive_push(3, 32'h518);
    ib_if.num_dispatched = 2'd3;
    step();
    flush = 1'b0;
    drive_push(0, 32'h0);
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL flush_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL flush_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    drive_push(1, 32'h100);
    step();
    drive_push(0, 32'h0);
    total++; if (ib_if.outputs_valid !== 2'd1) $display("FAIL postflush_ov: got %0d expected 1", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.dispatch_outputs[0].PC !== 32'h100) $display("FAIL postflush_pc0: got %0h expected 100", ib_if.dispatch_outputs[0].PC); else passed++;
    total++; if (ib_if.dispatch_outputs[0].NPC !== 32'h104) $display("FAIL postflush_npc0: got %0h expected 104", ib_if.dispatch_outputs[0].NPC); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_push(3, 32'h600);
    step();
    reset = 1'b1;
    drive_push(3, 32'h700);
    ib_if.num_dispatched = 2'd1;
    step();
    reset = 1'b0;
    drive_push(0, 32'h0);
    ib_if.num_dispatched = 2'd0;
    total++; if (ib_if.outputs_valid !== 2'd0) $display("FAIL midreset_ov: got %0d expected 0", ib_if.outputs_valid); else passed++;
    total++; if (ib_if.inst_buffer_spots !== 2'd3) $display("FAIL midreset_spots: got %0d expected 3", ib_if.inst_buffer_spots); else passed++;
    total++; if (ib_if.dispatch_outputs !== '0) $display("FAIL midreset_outputs: got %0h expected 0", ib_if.dispatch_outputs); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    ib_if.num_dispatched = 2'd0;
    drive_push(0, 32'h0);
    test_reset();
    test_push_basic();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
